// File: rtl/vrf_pkg.sv
// ----------------------------------------------------------------------------
// vrf_pkg
// Shared constants and types for one lane/bank of the vector register file.
//   VRF_DATA_W  : width of one bank word
//   VRF_DEPTH   : words per bank
//   VRF_ADDR_W  : word-address width (clog2 of VRF_DEPTH)
//   VRF_BYTES   : byte-enable lanes per word
//   vrf_state_t : responder sequencer state (zero-initialise, then serve)
//   vrf_word_t  : one bank word at the default width
// ----------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_DATA_W = 64;
    localparam int VRF_DEPTH  = 128;
    localparam int VRF_ADDR_W = 7;
    localparam int VRF_BYTES  = VRF_DATA_W / 8;

    typedef enum logic {
        VRF_INIT,
        VRF_RUN
    } vrf_state_t;

    typedef logic [VRF_DATA_W-1:0] vrf_word_t;

endpackage : vrf_pkg

// File: rtl/vrf_bank_ram.sv
// ----------------------------------------------------------------------------
// vrf_bank_ram
// Single-port, byte-masked synchronous RAM. A write and a read can never share
// a cycle; the read register only updates on a read access and otherwise holds.
//   clk    in   clock, rising edge
//   en     in   access enable
//   we     in   1 = write, 0 = read (when en=1)
//   addr   in   word address
//   wdata  in   write data
//   wmask  in   byte enables; bit k covers wdata[8k+7:8k]
//   rdata  out  registered read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
module vrf_bank_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int BYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BYTES-1:0]  wmask,
    output logic [DATA_W-1:0] rdata
);

    // NOTE: the storage array has no reset; clearing it is the job of the
    // responder's INIT sequencer, which keeps this mappable onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: every register here is written with <= so all reads in this edge
    // see pre-edge values; a read sees old data, never a same-edge write.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < BYTES; k++) begin
                    if (wmask[k]) begin
                        mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule : vrf_bank_ram

// File: rtl/vrf_bank_responder.sv
// ----------------------------------------------------------------------------
// vrf_bank_responder
// Responder for one bank of one lane of the vector register file. After reset
// it zero-fills the bank one word per cycle, then serves byte-masked writes
// and 1-cycle-latency reads, and flags illegal we&oe requests in a sticky err.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; restarts zero-fill at word 0
//   cs       in   chip select; requests are sampled only when cs=1
//   we       in   write enable
//   oe       in   read (output) enable
//   address  in   word address
//   wdata    in   write data
//   wmask    in   byte enables for writes
//   clr_err  in   clears err (a same-cycle new violation wins)
//   rdata    out  read data; holds the last read value between reads
//   rvalid   out  one-cycle strobe marking new rdata
//   ready    out  high once zero-fill has completed
//   err      out  sticky protocol-violation flag
// ----------------------------------------------------------------------------
module vrf_bank_responder
    import vrf_pkg::*;
#(
    parameter int DATA_W = VRF_DATA_W,
    parameter int DEPTH  = VRF_DEPTH,
    parameter int ADDR_W = VRF_ADDR_W,
    parameter int BYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BYTES-1:0]  wmask,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    vrf_state_t        state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    // Set by the first read after reset; until then rdata must read as zero,
    // even though the RAM's read register is not reset.
    logic              rd_seen_q, rd_seen_d;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BYTES-1:0]  ram_wmask;
    logic [DATA_W-1:0] ram_rdata;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rvalid_d   = 1'b0;
        err_d      = err_q & ~clr_err;
        rd_seen_d  = rd_seen_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = address;
        ram_wdata  = wdata;
        ram_wmask  = wmask;

        unique case (state_q)
            VRF_INIT: begin
                // Bus requests are ignored; the sequencer owns the RAM port.
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = init_ptr_q;
                ram_wdata  = '0;
                ram_wmask  = '1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_ADDR) begin
                    state_d = VRF_RUN;
                end
            end
            VRF_RUN: begin
                if (cs) begin
                    if (we) begin
                        // A write always happens; oe alongside it is a
                        // violation and suppresses the read.
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                        if (oe) begin
                            err_d = 1'b1;
                        end
                    end else if (oe) begin
                        ram_en    = 1'b1;
                        rvalid_d  = 1'b1;
                        rd_seen_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = VRF_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= VRF_INIT;
            init_ptr_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    vrf_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYTES  (BYTES)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .wmask (ram_wmask),
        .rdata (ram_rdata)
    );

    assign rdata  = rd_seen_q ? ram_rdata : '0;
    assign rvalid = rvalid_q;
    assign ready  = (state_q == VRF_RUN);
    assign err    = err_q;

endmodule : vrf_bank_responder

// File: tb/tb_vrf_bank_responder.sv
// ----------------------------------------------------------------------------
// tb_vrf_bank_responder
// Directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level model of the bank (array + counters).
// ----------------------------------------------------------------------------
module tb_vrf_bank_responder;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int BYTES  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [BYTES-1:0]  wmask;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              ready;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_init_done;   // zero-fill cycles completed since reset
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_err;

    vrf_bank_responder dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .oe      (oe),
        .address (address),
        .wdata   (wdata),
        .wmask   (wmask),
        .clr_err (clr_err),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .ready   (ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model by one transaction, then compare.
    task automatic drive_cycle(input logic c_rst, input logic c_cs, input logic c_we,
                               input logic c_oe, input logic [ADDR_W-1:0] c_addr,
                               input logic [DATA_W-1:0] c_wdata,
                               input logic [BYTES-1:0] c_wmask, input logic c_clr);
        rst = c_rst; cs = c_cs; we = c_we; oe = c_oe;
        address = c_addr; wdata = c_wdata; wmask = c_wmask; clr_err = c_clr;

        if (c_rst) begin
            // Contents are unobservable until zero-fill ends, so zero them now.
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_init_done = 0;
            m_rdata     = '0;
            m_rvalid    = 1'b0;
            m_err       = 1'b0;
        end else if (m_init_done < DEPTH) begin
            m_init_done++;
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = 1'b0;
            if (c_clr) m_err = 1'b0;
            if (c_cs && c_we) begin
                for (int k = 0; k < BYTES; k++)
                    if (c_wmask[k]) m_mem[c_addr][8*k +: 8] = c_wdata[8*k +: 8];
                if (c_oe) m_err = 1'b1;
            end else if (c_cs && c_oe) begin
                m_rdata  = m_mem[c_addr];
                m_rvalid = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        check("rvalid", 64'(rvalid), 64'(m_rvalid));
        check("rdata",  rdata,       m_rdata);
        check("ready",  64'(ready),  64'(m_init_done >= DEPTH));
        check("err",    64'(err),    64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [BYTES-1:0] m);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, a, d, m, 1'b0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, a, '0, '0, 1'b0);
    endtask

    task automatic reset_cycle();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Idle until ready, returning cycles counted after the reset edge.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            idle(1);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0;
        address = '0; wdata = '0; wmask = '0; clr_err = 1'b0;

        // Reset and zero-fill; ready is checked on every one of these cycles.
        reset_cycle();
        reset_cycle();
        idle(130);

        // Freshly zeroed words read back as zero, one cycle after request.
        rd(7'd0);   idle(1);
        rd(7'd63);  idle(1);
        rd(7'd127); idle(1);

        // Byte-masked merge.
        wr(7'd5, 64'h1122334455667788, 8'hFF);
        wr(7'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(7'd5);
        check("merge_word", rdata, 64'h11223344AAAAAAAA);
        idle(1);

        // Back-to-back reads keep rvalid high continuously.
        wr(7'd1, 64'h1, 8'hFF);
        wr(7'd2, 64'h2, 8'hFF);
        wr(7'd3, 64'h3, 8'hFF);
        rd(7'd1); rd(7'd2); rd(7'd3);
        idle(2);

        // we&oe violation: write lands, err set, no read; set beats clear.
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd9, 64'hDEAD, 8'hFF, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd10, 64'hBEEF, 8'hFF, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        rd(7'd9);
        check("wo_write", rdata, 64'hDEAD);
        idle(1);

        // Write during INIT is ignored.
        reset_cycle();
        idle(10);
        wr(7'd3, 64'h3333, 8'hFF);
        wait_ready(n);
        rd(7'd3);
        idle(1);

        // Reset in the middle of INIT restarts the full fill.
        reset_cycle();
        idle(50);
        reset_cycle();
        wait_ready(n);
        check("ready_latency", 64'(n), 64'd128);

        // Read then write same address: read sees old data, next read new.
        rd(7'd7);
        wr(7'd7, 64'h77, 8'hFF);
        rd(7'd7);
        check("raw_new", rdata, 64'h77);
        idle(1);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 599) == 0),
                        ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 1) == 0),
                        ADDR_W'($urandom_range(0, 15)),
                        {$urandom, $urandom},
                        BYTES'($urandom),
                        ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vrf_bank_responder
